// File: rtl/post_port_pkg.sv
// post_port_pkg: shared constants for the POST/debug I/O port.
// Holds the status/control bit layout and the default port address.
package post_port_pkg;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0080;

  // Control byte bits (status port write)
  localparam int CTL_CLR_OVF  = 7;
  localparam int CTL_IRQ_MASK = 1;
  localparam int CTL_FLUSH    = 0;

  // Value returned by a data-port read of an empty FIFO
  localparam logic [7:0] EMPTY_READ = 8'hFF;

  // Status byte as seen by the CPU
  typedef struct packed {
    logic       ovf;
    logic       full;
    logic       empty;
    logic [4:0] cnt;
  } status_t;

  // The status field only has five bits; deeper FIFOs report 31
  function automatic logic [4:0] sat_count(input logic [8:0] cnt);
    return (cnt > 9'd31) ? 5'd31 : cnt[4:0];
  endfunction

endpackage

// File: rtl/post_fifo.sv
// post_fifo: byte-wide synchronous FIFO with push/pop/flush.
// The caller never pushes into a full FIFO (unless popping the same cycle)
// and never pops an empty one. head_o reads 0 while empty.
module post_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  // Next pointers/count; flush overrides any same-cycle push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone says what is valid
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full_o  = count_q[DEPTH_LOG2];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_post_port.sv
// wb_post_port: Wishbone I/O responder capturing POST/debug bytes.
// BASE = data port (push on write, pop on read), BASE+1 = status/control.
// Bytes drain to a valid/ready consumer; CPU reads take priority.
// Optional feature macro: POST_PORT_IRQ_EN adds a maskable irq_o.
module wb_post_port
  import post_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [19:0] adr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  input  logic        we_i,
  input  logic        mio_i,
  input  logic        byte_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic [7:0]  drn_dat_o,
  output logic        drn_vld_o,
  input  logic        drn_rdy_i
`ifdef POST_PORT_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  logic                ack_q, ack_d;
  logic                ovf_q, ovf_d;
  logic                sel, act, data_acc, stat_acc;
  logic                data_wr, data_rd, stat_wr;
  logic [7:0]          stat_wdat, head, rd_byte;
  logic                fifo_push, fifo_pop, fifo_flush;
  logic                full, empty, cpu_pop, drn_pop, drop;
  logic [DEPTH_LOG2:0] count;
  logic [8:0]          cnt_ext;
  status_t             status;
  logic                unused_ok;

  assign sel = stb_i & mio_i & (adr_i[15:1] == BASE_ADDR[15:1]);

  // Port decode and FIFO arbitration; actions happen only in the ack cycle
  always_comb begin
    act        = ack_q & sel;
    data_acc   = act & (~byte_i | ~adr_i[0]);
    stat_acc   = act & (~byte_i | adr_i[0]);
    data_wr    = data_acc & we_i;
    data_rd    = data_acc & ~we_i;
    stat_wr    = stat_acc & we_i;
    stat_wdat  = byte_i ? dat_i[7:0] : dat_i[15:8];
    fifo_flush = stat_wr & stat_wdat[CTL_FLUSH];
    cpu_pop    = data_rd & ~empty;
    drn_vld_o  = ~empty & ~data_rd;
    drn_pop    = drn_vld_o & drn_rdy_i;
    fifo_pop   = (cpu_pop | drn_pop) & ~fifo_flush;
    // a drain pop frees the slot, so a full FIFO still accepts the byte
    fifo_push  = data_wr & (~full | drn_pop) & ~fifo_flush;
    drop       = data_wr & full & ~drn_pop & ~fifo_flush;
  end

  // Ack pulse (one wait state) and sticky overflow; a same-cycle drop beats clear
  always_comb begin
    ack_d = sel & ~ack_q;
    ovf_d = ovf_q;
    if (stat_wr && stat_wdat[CTL_CLR_OVF]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  // Bus-side state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      ovf_q <= ovf_d;
    end
  end

  post_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (dat_i[7:0]),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Read lanes; status always shows the state before this cycle's pop
  always_comb begin
    cnt_ext                = '0;
    cnt_ext[DEPTH_LOG2:0]  = count;
    status                 = '{ovf: ovf_q, full: full, empty: empty, cnt: sat_count(cnt_ext)};
    rd_byte                = empty ? EMPTY_READ : head;
    dat_o                  = 16'h0000;
    if (act && !we_i) begin
      if (!byte_i)        dat_o = {status, rd_byte};
      else if (adr_i[0])  dat_o = {8'h00, status};
      else                dat_o = {8'h00, rd_byte};
    end
  end

  assign ack_o     = ack_q;
  assign drn_dat_o = head;
  assign unused_ok = ^{adr_i[19:16], stat_wdat};

`ifdef POST_PORT_IRQ_EN
  logic mask_q, mask_d, irq_q, irq_d;

  // Mask follows bit1 of every status write; irq is at least half full or overflow
  always_comb begin
    mask_d = mask_q;
    if (stat_wr) mask_d = stat_wdat[CTL_IRQ_MASK];
    irq_d  = ~mask_q & (ovf_q | count[DEPTH_LOG2] | count[DEPTH_LOG2-1]);
  end

  // Interrupt state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule
